reset_conditioner: RTL and testbench



---
 rtl/reset_conditioner.sv | 205 ++++++++++++++++++++
 tb/tb_reset_conditioner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_conditioner.sv
// -----------------------------------------------------------------------------
// reset_conditioner
//
// Turns the raw reset sources of the VGA designs (PLL lock and a bouncy board
// push-button) into one clean, registered, active-high reset for the
// pixel-clock domain.
//
//   * PLL lock (reset_n) asserts the output immediately and releases it
//     synchronously through a 2-flop reset synchronizer.
//   * The push-button is synchronized, debounced, and each accepted press
//     re-enters the hold-off state and emits a one-cycle btn_event pulse.
//   * After every source has released, reset stays high for HOLD_CYCLES.
//
// Parameters:
//   SYNC_STAGES      flops in the button synchronizer (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed to accept
//                    a button level change (>= 2)
//   HOLD_CYCLES      cycles reset stays high after all sources release (>= 1)
//
// Ports:
//   clk        in   pixel clock
//   reset_n    in   asynchronous active-low reset (PLL LOCK)
//   btn_n      in   raw push-button, active-low, asynchronous, bouncy
//   reset      out  active-high reset for the video core, registered
//   btn_event  out  one-cycle pulse for each accepted button press
// -----------------------------------------------------------------------------
module reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 315000,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic reset,
  output logic btn_event
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("reset_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
    $error("reset_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("reset_conditioner: HOLD_CYCLES must be >= 1");
  end

  // Counter widths: just wide enough for the largest value each counter
  // reaches (N-1), so they can never wrap. HOLD_CYCLES == 1 would give a
  // zero-width counter, hence the floor of one bit.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Internal reset synchronizer: cleared asynchronously by reset_n, then
  // shifts in ones so the release reaches the rest of the block two edges
  // later and always synchronously to clk.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_chain_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_chain_q <= 2'b00;
    end else begin
      rst_chain_q <= {rst_chain_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_chain_q[1];

  // ---------------------------------------------------------------------------
  // Button synchronizer. Resets to 1 (button released) so a reset never looks
  // like a press.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   btn_s;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      btn_sync_q <= '1;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: count consecutive cycles in which the synchronized button
  // disagrees with the accepted level. Any agreement restarts the count; the
  // new level is accepted on the cycle the count has reached DEBOUNCE_CYCLES-1
  // and the input still disagrees.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic            press_accept;

  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b1;
      btn_db_prev_q <= 1'b1;
    end else begin
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
    end
  end

  // An accepted press is the registered falling edge of the debounced level.
  // Using the delayed copy puts btn_event and the reset re-assertion one edge
  // after btn_db falls, on the same cycle.
  assign press_accept = btn_db_prev_q & ~btn_db_q;

  // ---------------------------------------------------------------------------
  // Hold-off FSM
  //   HOLD: reset high; counts cycles with the button released, restarting
  //         while it is held, and moves to RUN after HOLD_CYCLES of them.
  //   RUN : reset low; an accepted press sends it back to HOLD.
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                reset_q, reset_d;
  logic                btn_event_q, btn_event_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    btn_event_d = press_accept;

    case (state_q)
      ST_HOLD: begin
        if (!btn_db_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_RUN: begin
        hold_cnt_d = '0;
        if (press_accept) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase

    // Registering from the next state keeps reset glitch-free and lets it
    // rise on the same edge the FSM leaves RUN.
    reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      reset_q     <= 1'b1;
      btn_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      reset_q     <= reset_d;
      btn_event_q <= btn_event_d;
    end
  end

  assign reset     = reset_q;
  assign btn_event = btn_event_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// -----------------------------------------------------------------------------
// tb_reset_conditioner
//
// Self-checking bench for reset_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, HOLD_CYCLES=16.
//   * Directed part: a table of input segments, each with the expected edge
//     at which reset first changes, the final reset level, the number of
//     btn_event pulses and the edge of the first pulse; plus hand-written
//     sequences for power-up and asynchronous reset assertion.
//   * Random part: random button bursts and reset_n pulses, compared every
//     cycle against a behavioural model built from the timing rules.
// -----------------------------------------------------------------------------
module tb_reset_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_n;
  logic reset;
  logic btn_event;

  reset_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_n    (btn_n),
    .reset    (reset),
    .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model.
  //   e        : edges counted since reset_n went high (edge 1 = first)
  //   hist     : btn_n samples, hist[k-1] taken at edge k
  //   btn_s after edge x = btn_n sampled at edge x-SYNC+1, or 1 if that edge
  //                        came before the internal release (edge < 3)
  //   db flips at an edge when the previous DEB synchronized values all
  //   differ from it; reset drops after HOLD consecutive edges with db high
  //   while not running; a fall of db is reported and re-arms reset one
  //   edge later.
  // ---------------------------------------------------------------------------
  int  m_e;
  bit  m_hist[$];
  bit  m_db_cur, m_db_old, m_run;
  int  m_streak;
  bit  m_exp_reset, m_exp_evt;
  bit  mdl_chk = 1'b0;

  function automatic bit m_bs(input int x);
    int k;
    k = x - SYNC + 1;
    if (k < 3) return 1'b1;
    return m_hist[k-1];
  endfunction

  task automatic model_edge(input bit rn, input bit b);
    bit fall;
    bit flip;
    if (!rn) begin
      m_e = 0;
      m_hist.delete();
      m_db_cur = 1'b1;
      m_db_old = 1'b1;
      m_run = 1'b0;
      m_streak = 0;
      m_exp_reset = 1'b1;
      m_exp_evt = 1'b0;
    end else begin
      m_e++;
      m_hist.push_back(b);
      if (m_e >= 3) begin
        fall = !m_db_cur && m_db_old;
        m_exp_evt = fall;
        if (m_run) begin
          if (fall) begin
            m_run = 1'b0;
            m_streak = 0;
          end
        end else if (m_db_cur) begin
          m_streak++;
          if (m_streak == HOLD) begin
            m_run = 1'b1;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          if (m_bs(m_e - j) == m_db_cur) flip = 1'b0;
        end
        m_db_old = m_db_cur;
        if (flip) m_db_cur = !m_db_cur;
        m_exp_reset = !m_run;
      end else begin
        m_exp_reset = 1'b1;
        m_exp_evt = 1'b0;
      end
    end
  endtask

  // One clock edge; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    bit rn_s;
    bit b_s;
    rn_s = reset_n;
    b_s  = btn_n;
    @(posedge clk);
    #1;
    model_edge(rn_s, b_s);
    if (mdl_chk) begin
      check("model reset", int'(reset), int'(m_exp_reset));
      check("model btn_event", int'(btn_event), int'(m_exp_evt));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed segment table
  // ---------------------------------------------------------------------------
  typedef struct {
    string name;
    bit    rst_n;
    bit    btn;
    int    cycles;
    int    chg_edge;   // edge at which reset first changes, 0 = never
    bit    end_reset;  // reset after the last edge
    int    events;     // btn_event pulses seen in the segment
    int    evt_edge;   // edge of first btn_event, 0 = none
  } vec_t;

  function automatic vec_t mk(input string name, input bit rst_n, input bit btn,
                              input int cycles, input int chg_edge,
                              input bit end_reset, input int events,
                              input int evt_edge);
    vec_t v;
    v.name = name;
    v.rst_n = rst_n;
    v.btn = btn;
    v.cycles = cycles;
    v.chg_edge = chg_edge;
    v.end_reset = end_reset;
    v.events = events;
    v.evt_edge = evt_edge;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    bit r0;
    int chg;
    int nev;
    int fe;
    reset_n = v.rst_n;
    btn_n   = v.btn;
    #1;
    r0  = reset;
    chg = 0;
    nev = 0;
    fe  = 0;
    for (int i = 1; i <= v.cycles; i++) begin
      tick();
      if (chg == 0 && reset != r0) chg = i;
      if (btn_event) begin
        nev++;
        if (fe == 0) fe = i;
      end
    end
    $display("seg %-24s rst_n=%0b btn_n=%0b cyc=%0d reset_chg_edge=%0d events=%0d first_evt=%0d reset=%0b",
             v.name, v.rst_n, v.btn, v.cycles, chg, nev, fe, reset);
    check({v.name, " reset change edge"}, chg, v.chg_edge);
    check({v.name, " final reset"}, int'(reset), int'(v.end_reset));
    check({v.name, " event count"}, nev, v.events);
    check({v.name, " event edge"}, fe, v.evt_edge);
  endtask

  task automatic async_pulse(input string name, input bit btn_during);
    reset_n = 1'b0;
    btn_n   = btn_during;
    #1;
    $display("async reset_n pulse (%s): reset=%0b btn_event=%0b", name, reset, btn_event);
    check({name, " async reset assert"}, int'(reset), 1);
    check({name, " async btn_event clear"}, int'(btn_event), 0);
    tick();
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    btn_n   = 1'b1;
    model_edge(1'b0, 1'b1);

    // Power-up: reset_n low for 5 cycles, outputs held at reset values.
    for (int i = 1; i <= 5; i++) begin
      tick();
      $display("powerup cycle %0d: reset=%0b btn_event=%0b", i, reset, btn_event);
      check("powerup reset", int'(reset), 1);
      check("powerup btn_event", int'(btn_event), 0);
    end

    // Release, glitches, press/release.
    vecs.push_back(mk("powerup release", 1, 1, 30, 18, 0, 0, 0));
    vecs.push_back(mk("glitch 7 low", 1, 0, 7, 0, 0, 0, 0));
    vecs.push_back(mk("glitch recover", 1, 1, 20, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk("burst low 3", 1, 0, 3, 0, 0, 0, 0));
      vecs.push_back(mk("burst high 1", 1, 1, 1, 0, 0, 0, 0));
    end
    vecs.push_back(mk("burst settle", 1, 1, 10, 0, 0, 0, 0));
    vecs.push_back(mk("press 30", 1, 0, 30, 11, 1, 1, 11));
    vecs.push_back(mk("release", 1, 1, 40, 26, 0, 0, 0));
    foreach (vecs[i]) run_vec(vecs[i]);
    vecs.delete();

    // Async reset in RUN.
    async_pulse("in RUN", 1'b1);
    run_vec(mk("recover after RUN pulse", 1, 1, 30, 18, 0, 0, 0));

    // Async reset mid-debounce (counter at 5 after 7 low cycles).
    run_vec(mk("debounce to count 5", 1, 0, 7, 0, 0, 0, 0));
    async_pulse("mid-debounce", 1'b1);
    run_vec(mk("recover after db pulse", 1, 1, 30, 18, 0, 0, 0));

    // Button held across power-up.
    reset_n = 1'b0;
    btn_n   = 1'b0;
    #1;
    check("held-btn async reset", int'(reset), 1);
    for (int i = 0; i < 3; i++) tick();
    vecs.push_back(mk("held btn powerup", 1, 0, 30, 0, 1, 1, 13));
    vecs.push_back(mk("held btn release", 1, 1, 40, 26, 0, 0, 0));

    // Hold re-trigger: second press accepted with the hold counter at 10.
    vecs.push_back(mk("retrig press", 1, 0, 30, 11, 1, 1, 11));
    vecs.push_back(mk("retrig short release", 1, 1, 10, 0, 1, 0, 0));
    vecs.push_back(mk("retrig press in HOLD", 1, 0, 30, 0, 1, 1, 11));
    vecs.push_back(mk("retrig final release", 1, 1, 40, 26, 0, 0, 0));
    foreach (vecs[i]) run_vec(vecs[i]);
    vecs.delete();

    // Random phase against the reference model.
    reset_n = 1'b0;
    btn_n   = 1'b1;
    tick();
    mdl_chk = 1'b1;
    reset_n = 1'b1;
    for (int burst = 0; burst < 160; burst++) begin
      int len;
      int nevt;
      if ($urandom_range(0, 24) == 0) begin
        len = $urandom_range(1, 3);
        reset_n = 1'b0;
        btn_n   = 1'($urandom_range(0, 1));
        #1;
        check("random async reset assert", int'(reset), 1);
        for (int i = 0; i < len; i++) tick();
        reset_n = 1'b1;
        $display("rand burst %0d: reset_n pulse %0d cycles", burst, len);
      end else begin
        btn_n = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 45);
        else len = $urandom_range(1, 9);
        nevt = 0;
        for (int i = 0; i < len; i++) begin
          tick();
          if (btn_event) nevt++;
        end
        $display("rand burst %0d: btn_n=%0b for %0d cycles, reset=%0b events=%0d",
                 burst, btn_n, len, reset, nevt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
